// File: rtl/serial165_chain_reader_if.sv
// Host-side bus and 74HC165 chain signals of the serial165 chain reader.
// The master modport drives scan requests, read addresses and the chains' serial data.
interface serial165_chain_reader_if #(
    parameter int LINES_NUM  = 8,
    parameter int LINE_BYTES = 1
);
    localparam int N      = 8 * LINE_BYTES;
    localparam int DATA_W = LINES_NUM * N;

    logic                 start;
    logic [LINES_NUM-1:0] sdataIn;
    logic                 nPL;
    logic                 shClk;
    logic                 busy;
    logic                 valid;
    logic [DATA_W-1:0]    data;
    logic [15:0]          address;
    logic [15:0]          rdData;

    modport master (
        output start, sdataIn, address,
        input  nPL, shClk, busy, valid, data, rdData
    );

    modport slave (
        input  start, sdataIn, address,
        output nPL, shClk, busy, valid, data, rdData
    );
endinterface

// File: rtl/serial165_chain_reader.sv
// Scans daisy-chained 74HC165 input registers into a parallel snapshot with 16-bit read slices.
// Optional feature: define SERIAL165_DEBOUNCE_EN to only accept bits that agree across two scans.
module serial165_chain_reader #(
    parameter int LINES_NUM  = 8,
    parameter int LINE_BYTES = 1,
    parameter int CLK_DIV    = 4
) (
    input logic hclk,
    input logic rst,
    serial165_chain_reader_if.slave bus
);
    localparam int N      = 8 * LINE_BYTES;
    localparam int DATA_W = LINES_NUM * N;
    localparam int SLICES = (DATA_W + 15) / 16;
    localparam int PAD_W  = SLICES * 16;
    localparam int BIT_W  = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [7:0]           r_div;
    logic                 w_divLast;
    logic [BIT_W-1:0]     r_bitIdx;
    logic                 w_sample;
    logic [LINES_NUM-1:0] r_sync1;
    logic [LINES_NUM-1:0] r_sync2;
    logic [N-1:0]         r_shadow [LINES_NUM];
    logic [DATA_W-1:0]    w_raw;
    logic [DATA_W-1:0]    w_dataNext;
    logic                 w_nPLNext;
    logic                 w_shClkNext;
    logic                 w_busyNext;
    logic                 w_validNext;
    logic                 r_nPL;
    logic                 r_shClk;
    logic                 r_busy;
    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [PAD_W-1:0]     w_padded;
    logic [15:0]          w_rdNext;
    logic [15:0]          r_rdData;

    assign w_divLast = (r_div == 8'(CLK_DIV - 1));

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pin levels are registered from the current state, so every output lags the state by one hclk.
    always_comb begin
        w_nextState = r_state;
        w_sample    = 1'b0;
        w_nPLNext   = (r_state != S_LOAD);
        w_shClkNext = (r_state == S_SHIFT_HI);
        w_busyNext  = (r_state != S_IDLE);
        w_validNext = (r_state == S_DONE);
        case (r_state)
            S_IDLE:     if (bus.start) w_nextState = S_LOAD;
            S_LOAD:     if (w_divLast) w_nextState = S_SETTLE;
            S_SETTLE: begin
                if (w_divLast) begin
                    w_sample    = 1'b1;
                    w_nextState = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: if (w_divLast) w_nextState = S_SHIFT_LO;
            S_SHIFT_LO: begin
                if (w_divLast) begin
                    w_sample    = 1'b1;
                    w_nextState = (r_bitIdx == BIT_W'(N - 1)) ? S_DONE : S_SHIFT_HI;
                end
            end
            S_DONE:     w_nextState = S_IDLE;
            default:    w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_bitIdx <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DONE || r_state != w_nextState) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 8'd1;
            end
            if (w_sample) begin
                r_bitIdx <= (r_state == S_SETTLE) ? BIT_W'(1) : r_bitIdx + BIT_W'(1);
            end
        end
    end

    // Each line shifts in at its LSB, so after N samples the first one sits at the line's MSB.
    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            for (int l = 0; l < LINES_NUM; l++) begin
                r_shadow[l] <= '0;
            end
        end else begin
            r_sync1 <= bus.sdataIn;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                for (int l = 0; l < LINES_NUM; l++) begin
                    r_shadow[l] <= {r_shadow[l][N-2:0], r_sync2[l]};
                end
            end
        end
    end

    always_comb begin
        w_raw = '0;
        for (int l = 0; l < LINES_NUM; l++) begin
            w_raw[l*N +: N] = r_shadow[l];
        end
    end

`ifdef SERIAL165_DEBOUNCE_EN
    logic [DATA_W-1:0] r_rawPrev;
    logic [DATA_W-1:0] w_diff;

    assign w_diff     = w_raw ^ r_rawPrev;
    assign w_dataNext = (w_raw & ~w_diff) | (r_data & w_diff);

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            r_rawPrev <= '0;
        end else if (r_state == S_DONE) begin
            r_rawPrev <= w_raw;
        end
    end
`else
    assign w_dataNext = w_raw;
`endif

    always_comb begin
        w_padded               = '0;
        w_padded[DATA_W-1:0]   = r_data;
        w_rdNext               = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (bus.address == 16'(s)) w_rdNext = w_padded[s*16 +: 16];
        end
    end

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            r_nPL    <= 1'b1;
            r_shClk  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_rdData <= '0;
        end else begin
            r_nPL    <= w_nPLNext;
            r_shClk  <= w_shClkNext;
            r_busy   <= w_busyNext;
            r_valid  <= w_validNext;
            r_rdData <= w_rdNext;
            if (r_state == S_DONE) r_data <= w_dataNext;
        end
    end

    assign bus.nPL    = r_nPL;
    assign bus.shClk  = r_shClk;
    assign bus.busy   = r_busy;
    assign bus.valid  = r_valid;
    assign bus.data   = r_data;
    assign bus.rdData = r_rdData;
endmodule

// File: tb/tb_serial165_chain_reader.sv
// Scoreboard bench for serial165_chain_reader with a behavioural 74HC165 chain model.
// Expected snapshots are queued at stimulus time and compared whenever the DUT pulses valid.
module tb_serial165_chain_reader;
    localparam int LINES   = 8;
    localparam int LB      = 1;
    localparam int N       = 8 * LB;
    localparam int W       = LINES * N;
    localparam int DIV     = 4;
    localparam int SLICES  = (W + 15) / 16;
    localparam int LATENCY = 1 + 2 * DIV * N;
    localparam int PERIOD  = LATENCY + 1;

    logic hclk = 1'b0;
    logic rst  = 1'b1;

    serial165_chain_reader_if #(.LINES_NUM(LINES), .LINE_BYTES(LB)) bus();

    serial165_chain_reader #(
        .LINES_NUM (LINES),
        .LINE_BYTES(LB),
        .CLK_DIV   (DIV)
    ) dut (
        .hclk(hclk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 hclk = ~hclk;

    logic [N-1:0] par [LINES];
    logic [N-1:0] sr  [LINES];
    logic [W-1:0] expQ [$];
    int           validCyc [$];
    logic [W-1:0] modelData = '0;
    logic [W-1:0] modelPrev = '0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    // A 165 chain: parallel load while nPL is low, shift towards Q7 on each shClk rise.
    always @(negedge bus.nPL or posedge bus.shClk) begin
        for (int l = 0; l < LINES; l++) begin
            if (!bus.nPL) sr[l] <= par[l];
            else          sr[l] <= sr[l] << 1;
        end
    end

    always_comb begin
        bus.sdataIn = '0;
        for (int l = 0; l < LINES; l++) bus.sdataIn[l] = sr[l][N-1];
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Reference: line l's parallel byte lands at data[l*N +: N]; debounce accepts only repeated bits.
    task automatic predictScan();
        logic [W-1:0] raw;
        raw = '0;
        for (int l = 0; l < LINES; l++) raw[l*N +: N] = par[l];
`ifdef SERIAL165_DEBOUNCE_EN
        for (int b = 0; b < W; b++) begin
            if (raw[b] == modelPrev[b]) modelData[b] = raw[b];
        end
        modelPrev = raw;
`else
        modelData = raw;
`endif
        expQ.push_back(modelData);
    endtask

    always @(negedge hclk) begin
        if (!rst && bus.valid) begin
            validCyc.push_back(cyc);
            if (expQ.size() == 0) begin
                checkOutput("spuriousValid", W'(bus.valid), '0);
            end else begin
                checkOutput("scanData", bus.data, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit checkTiming);
        int n, nplLow, rises;
        bit seen, prevSh;
        predictScan();
        @(negedge hclk);
        bus.start = 1'b1;
        @(posedge hclk);
        n = 0; nplLow = 0; rises = 0; seen = 1'b0; prevSh = bus.shClk;
        while (!seen && n < 300) begin
            @(negedge hclk);
            bus.start = 1'b0;
            n++;
            if (!bus.nPL) nplLow++;
            if (bus.shClk && !prevSh) rises++;
            prevSh = bus.shClk;
            if (n == 10) checkOutput("busyMidScan", W'(bus.busy), W'(1));
            if (bus.valid) seen = 1'b1;
        end
        checkOutput("scanCompleted", W'(seen), W'(1));
        if (checkTiming) begin
            checkOutput("validLatency", W'(n - 1), W'(LATENCY));
            checkOutput("nPLLowCycles", W'(nplLow), W'(DIV));
            checkOutput("shClkRises", W'(rises), W'(N - 1));
            @(negedge hclk);
            checkOutput("busyAfterDone", W'(bus.busy), '0);
        end
    endtask

    task automatic checkRead(input int addr);
        logic [W-1:0] shifted;
        logic [15:0]  want;
        want = '0;
        if (addr < SLICES) begin
            shifted = modelData >> (addr * 16);
            want    = shifted[15:0];
        end
        @(negedge hclk);
        bus.address = 16'(addr);
        @(negedge hclk);
        checkOutput($sformatf("rdData[%0d]", addr), W'(bus.rdData), W'(want));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_nPL"},    W'(bus.nPL),    W'(1));
        checkOutput({tag, "_shClk"},  W'(bus.shClk),  '0);
        checkOutput({tag, "_busy"},   W'(bus.busy),   '0);
        checkOutput({tag, "_valid"},  W'(bus.valid),  '0);
        checkOutput({tag, "_data"},   bus.data,       '0);
        checkOutput({tag, "_rdData"}, W'(bus.rdData), '0);
    endtask

    task automatic setPar(input logic [N-1:0] line0, input logic [N-1:0] line7);
        for (int l = 0; l < LINES; l++) par[l] = '0;
        par[0]       = line0;
        par[LINES-1] = line7;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.address = '0;
        for (int l = 0; l < LINES; l++) begin
            par[l] = '0;
            sr[l]  = '0;
        end

        #12;
        checkResetValues("powerOnReset");
        @(negedge hclk);
        rst = 1'b0;
        repeat (3) @(negedge hclk);

        $display("[TB] directed scan, line0=A5 line7=3C");
        setPar(8'hA5, 8'h3C);
        applyStimulus(1'b1);
        checkRead(0);
        checkRead(3);
        checkRead(4);

        $display("[TB] reset at cycle 20 of a scan");
        checkRead(0);
        @(negedge hclk);
        bus.start = 1'b1;
        @(posedge hclk);
        repeat (20) begin
            @(negedge hclk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1 checkResetValues("midScanReset");
        expQ.delete();
        modelData = '0;
        modelPrev = '0;
        repeat (5) @(negedge hclk);
        rst = 1'b0;
        repeat (100) @(negedge hclk);
        checkOutput("dataAfterAbort", bus.data, modelData);
        setPar(8'h5A, 8'hC3);
        applyStimulus(1'b1);

        $display("[TB] line0 sequence A5 A5 FF FF");
        foreach (par[l]) par[l] = '0;
        par[0] = 8'hA5; applyStimulus(1'b0);
        par[0] = 8'hA5; applyStimulus(1'b0);
        par[0] = 8'hFF; applyStimulus(1'b0);
        par[0] = 8'hFF; applyStimulus(1'b0);
        checkRead(0);

        $display("[TB] start held high for 200 cycles");
        for (int l = 0; l < LINES; l++) par[l] = N'($urandom);
        validCyc.delete();
        repeat (4) predictScan();
        @(negedge hclk);
        bus.start = 1'b1;
        repeat (200) @(posedge hclk);
        #1 bus.start = 1'b0;
        repeat (200) @(negedge hclk);
        checkOutput("backToBackValids", W'(validCyc.size()), W'(4));
        for (int i = 1; i < validCyc.size(); i++) begin
            checkOutput($sformatf("validGap%0d", i), W'(validCyc[i] - validCyc[i-1]), W'(PERIOD));
        end
        checkOutput("queueDrained", W'(expQ.size()), '0);

        $display("[TB] randomized scans");
        for (int r = 0; r < 8; r++) begin
            for (int l = 0; l < LINES; l++) par[l] = N'($urandom);
            applyStimulus(1'b1);
            checkRead(int'($urandom_range(0, SLICES + 1)));
            repeat ($urandom_range(0, 5)) @(negedge hclk);
        end
        checkOutput("finalQueueDrained", W'(expQ.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
